// File: rtl/fifo_uart_tx_if.sv
// FIFO-read / serial-line bundle for fifo_uart_tx.
// master: the transmitter; slave: the FIFO and line consumer side.
interface fifo_uart_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             tx_en;
  logic             empty;
  logic [WIDTH-1:0] rdata;
  logic             rd_en;
  logic             tx;
  logic             busy;
  logic             frame_done;
  logic [15:0]      frame_cnt;

  modport master (
    input  tx_en, empty, rdata,
    output rd_en, tx, busy, frame_done, frame_cnt
  );

  modport slave (
    output tx_en, empty, rdata,
    input  rd_en, tx, busy, frame_done, frame_cnt
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops words from a FIFO and sends each as a start/WIDTH data/stop serial frame.
// All outputs come from registers loaded with the value matching the next state.
module fifo_uart_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic          clk,
  input  logic          rst,
  fifo_uart_tx_if.master bus
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] TLAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] POP   = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             rd_en_q, rd_en_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             rst_done_q;
  logic             bit_end;
  logic             can_pop;

  // Pop only after one full clock out of reset, and only when a word is known present.
  always_comb begin
    state_d      = state_q;
    timer_d      = '0;
    bit_d        = bit_q;
    shift_d      = shift_q;
    tx_d         = 1'b1;
    rd_en_d      = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    bit_end      = (timer_q == TLAST);
    can_pop      = bus.tx_en && !bus.empty && rst_done_q;

    case (state_q)
      IDLE: begin
        bit_d = '0;
        if (can_pop) state_d = POP;
      end
      POP:  state_d = LOAD;
      LOAD: begin
        shift_d = bus.rdata;
        state_d = START;
      end
      START: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) begin
          if (bit_q == BLAST) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
      STOP: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) state_d = can_pop ? POP : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Output values describe the state being entered, so the registers line up with state_q.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    rd_en_d      = (state_d == POP);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == STOP) && (timer_d == TLAST);
    if (frame_done_d) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      rst_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      rst_done_q   <= 1'b1;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx (CLKS_PER_BIT=4, WIDTH=8) with a small FIFO model.
module tb_fifo_uart_tx;

  localparam int unsigned CPB = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   pops;
  int   underflows;
  int   garble;
  logic [7:0] q[$];

  fifo_uart_tx_if #(.WIDTH(8)) bus ();

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: word appears on rdata after a pop, then is corrupted once LOAD has passed.
  always @(negedge clk) begin
    if (rst) begin
      garble = 0;
    end else if (bus.rd_en === 1'b1) begin
      pops++;
      if (q.size() == 0) underflows++;
      else begin
        bus.rdata = q.pop_front();
        garble = 2;
      end
    end else if (garble > 0) begin
      garble--;
      if (garble == 0) bus.rdata = ~bus.rdata;
    end
    bus.empty = (q.size() == 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for a start bit, then checks all 40 line samples and the frame_done pulse.
  task automatic check_frame(input logic [7:0] w, input string nm, input int drop_at,
                             output int gap);
    int   waited;
    int   bad;
    int   first_bad;
    int   fd_bad;
    int   b;
    logic e;
    logic got;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.tx !== 1'b0 && waited < 300);
    checks++;
    if (bus.tx !== 1'b0) begin
      failures++;
      $display("FAIL %s_start: tx=%b after %0d cycles, required 0", nm, bus.tx, waited);
      gap = -1;
      return;
    end
    gap = waited - 1;
    bad = 0; first_bad = -1; fd_bad = 0; got = 1'b0; e = 1'b0;
    for (int s = 0; s < 40; s++) begin
      if (s > 0) @(negedge clk);
      if (s == drop_at) bus.tx_en = 1'b0;
      b = s / 4;
      e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : w[b-1];
      if (bus.tx !== e) begin
        if (first_bad < 0) begin
          first_bad = s;
          got = bus.tx;
        end
        bad++;
      end
      if (bus.frame_done !== (s == 39)) fd_bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_tx: %0d bad samples, first at sample %0d got %b, required %b",
               nm, bad, first_bad, got, (first_bad / 4 == 0) ? 1'b0 :
               (first_bad / 4 == 9) ? 1'b1 : w[first_bad/4-1]);
    end
    checks++;
    if (fd_bad != 0) begin
      failures++;
      $display("FAIL %s_frame_done: %0d wrong samples, required a single pulse in last stop cycle",
               nm, fd_bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b, required 1", bus.tx); end
    checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b, required 0", bus.rd_en); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b, required 0", bus.frame_done); end
    checks++; if (bus.frame_cnt !== 16'h0000) begin failures++; $display("FAIL reset_frame_cnt: got %h, required 0000", bus.frame_cnt); end
  endtask

  task automatic test_single_frame();
    int gap;
    int p0;
    q.push_back(8'hA5);
    bus.tx_en = 1'b1;
    repeat (2) @(negedge clk);
    p0 = pops;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL first_edge_rd_en: got %b, required 0", bus.rd_en); end
    @(negedge clk);
    checks++; if (bus.rd_en !== 1'b1) begin failures++; $display("FAIL second_edge_rd_en: got %b, required 1", bus.rd_en); end
    check_frame(8'hA5, "a5", -1, gap);
    repeat (4) @(negedge clk);
    checks++; if (pops - p0 != 1) begin failures++; $display("FAIL a5_rd_en_cycles: got %0d, required 1", pops - p0); end
    checks++; if (bus.frame_cnt !== 16'd1) begin failures++; $display("FAIL a5_frame_cnt: got %0d, required 1", bus.frame_cnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL a5_busy_after: got %b, required 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int gap;
    int p0;
    p0 = pops;
    q.push_back(8'h01);
    q.push_back(8'h80);
    q.push_back(8'hFF);
    check_frame(8'h01, "b2b_01", -1, gap);
    check_frame(8'h80, "b2b_80", -1, gap);
    checks++; if (gap != 2) begin failures++; $display("FAIL b2b_gap1: got %0d high cycles, required 2", gap); end
    check_frame(8'hFF, "b2b_ff", -1, gap);
    checks++; if (gap != 2) begin failures++; $display("FAIL b2b_gap2: got %0d high cycles, required 2", gap); end
    repeat (5) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_busy: got %b, required 0", bus.busy); end
    checks++; if (bus.frame_cnt !== 16'd4) begin failures++; $display("FAIL b2b_frame_cnt: got %0d, required 4", bus.frame_cnt); end
    checks++; if (pops - p0 != 3) begin failures++; $display("FAIL b2b_pops: got %0d, required 3", pops - p0); end
    checks++; if (underflows != 0) begin failures++; $display("FAIL b2b_underflow: got %0d, required 0", underflows); end
  endtask

  task automatic test_idle_empty();
    int bad;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rd_en !== 1'b0 || bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL idle_empty: %0d bad cycles, required 0", bad); end
  endtask

  task automatic test_tx_en_drop();
    int gap;
    int p0;
    int bad;
    q.push_back(8'h3C);
    q.push_back(8'h96);
    check_frame(8'h3C, "drop_3c", 16, gap);
    p0 = pops; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.tx !== 1'b1) bad++;
    end
    checks++; if (pops != p0) begin failures++; $display("FAIL drop_no_pop: got %0d pops, required 0", pops - p0); end
    checks++; if (bad != 0) begin failures++; $display("FAIL drop_idle: %0d bad cycles, required 0", bad); end
    bus.tx_en = 1'b1;
    @(negedge clk);
    checks++; if (bus.rd_en !== 1'b1) begin failures++; $display("FAIL resume_rd_en: got %b, required 1", bus.rd_en); end
    check_frame(8'h96, "resume_96", -1, gap);
    @(negedge clk);
    checks++; if (bus.frame_cnt !== 16'd6) begin failures++; $display("FAIL drop_frame_cnt: got %0d, required 6", bus.frame_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int gap;
    int waited;
    q.push_back(8'hC3);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.tx !== 1'b0 && waited < 300);
    repeat (20) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %b, required 1", bus.busy); end
    rst = 1'b1;
    #1;
    checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL mid_rst_tx: got %b, required 1", bus.tx); end
    checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL mid_rst_rd_en: got %b, required 0", bus.rd_en); end
    checks++; if (bus.frame_cnt !== 16'd0) begin failures++; $display("FAIL mid_rst_frame_cnt: got %0d, required 0", bus.frame_cnt); end
    @(negedge clk);
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL mid_rst_frame_done: got %b, required 0", bus.frame_done); end
    rst = 1'b0;
    q.push_back(8'h5A);
    check_frame(8'h5A, "fresh_5a", -1, gap);
    @(negedge clk);
    checks++; if (bus.frame_cnt !== 16'd1) begin failures++; $display("FAIL fresh_frame_cnt: got %0d, required 1", bus.frame_cnt); end
  endtask

  task automatic test_wrap();
    int gap;
    repeat (4) @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    checks++; if (bus.frame_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload: got %h, required ffff", bus.frame_cnt); end
    q.push_back(8'h7E);
    check_frame(8'h7E, "wrap_7e", -1, gap);
    checks++; if (bus.frame_cnt !== 16'h0000) begin failures++; $display("FAIL wrap_frame_cnt: got %h, required 0000", bus.frame_cnt); end
  endtask

  initial begin
    checks = 0; failures = 0; pops = 0; underflows = 0; garble = 0;
    rst = 1'b1;
    bus.tx_en = 1'b0;
    bus.empty = 1'b1;
    bus.rdata = 8'h00;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_idle_empty();
    test_tx_en_drop();
    test_reset_mid_frame();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
